// File: rtl/midi_pkg.sv
// Shared MIDI definitions: byte-class boundaries, parser state encoding and
// the status-byte to data-byte-count lookup, which the router also uses.
package midi_pkg;

    localparam logic [7:0] STATUS_MIN  = 8'h80;
    localparam logic [7:0] RT_MIN      = 8'hF8;
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] TUNE_REQ    = 8'hF6;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        SYSEX
    } state_t;

    // Number of data bytes that follow a status byte (0 for F0, F4..F7).
    function automatic logic [1:0] data_count(input logic [7:0] status);
        logic [1:0] cnt;
        cnt = 2'd0;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: cnt = 2'd2;
            4'hC, 4'hD:                   cnt = 2'd1;
            4'hF: begin
                case (status[3:0])
                    4'h1, 4'h3: cnt = 2'd1;
                    4'h2:       cnt = 2'd2;
                    default:    cnt = 2'd0;
                endcase
            end
            default: cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Byte-stream input and assembled-message outputs of one MIDI parser.
//   rxdv/rxdata            : received byte strobe and byte
//   msg_*                  : complete message (pulse + held fields)
//   rt_valid/rt_byte       : real-time byte pulse
//   sysex_active           : inside a SysEx frame
//   err_pulse/err_count    : protocol error pulse and saturating count
// slave = the parser, master = the byte source / message consumer.
interface midi_msg_parser_if #(
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 rxdv;
    logic [7:0]           rxdata;
    logic                 msg_valid;
    logic [7:0]           msg_status;
    logic [6:0]           msg_data1;
    logic [6:0]           msg_data2;
    logic [1:0]           msg_len;
    logic                 rt_valid;
    logic [7:0]           rt_byte;
    logic                 sysex_active;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  rxdv, rxdata,
        output msg_valid, msg_status, msg_data1, msg_data2, msg_len,
        output rt_valid, rt_byte, sysex_active, err_pulse, err_count
    );

    modport master (
        output rxdv, rxdata,
        input  msg_valid, msg_status, msg_data1, msg_data2, msg_len,
        input  rt_valid, rt_byte, sysex_active, err_pulse, err_count
    );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI message parser for one port: assembles channel voice, system common
// and real-time messages from the received byte stream, with running status,
// SysEx framing and protocol-error counting.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : midi_msg_parser_if slave (byte input, message/status outputs)
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int unsigned ERR_CNT_W      = 8,
    parameter bit          RUNNING_STATUS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    midi_msg_parser_if.slave   bus
);

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    state_t               state;
    logic [7:0]           cur_status;
    logic [7:0]           run_status;
    logic                 run_valid;
    logic [6:0]           d1_q;
    logic [ERR_CNT_W-1:0] err_cnt;

    logic       is_rt;
    logic       is_data;
    logic       rs_ok;
    logic       err_now;
    logic [6:0] data7;

    assign bus.err_count = err_cnt;

    always_comb begin
        is_rt   = bus.rxdata >= RT_MIN;
        is_data = bus.rxdata < STATUS_MIN;
        rs_ok   = RUNNING_STATUS && run_valid;
        data7   = bus.rxdata[6:0];
        err_now = 1'b0;
        if (bus.rxdv && !is_rt) begin
            if (is_data) begin
                err_now = (state == IDLE) && !rs_ok;
            end else if (!(state == SYSEX && bus.rxdata == SYSEX_END)) begin
                // Any status outside IDLE truncates a message or aborts SysEx;
                // a stray F7 is an error on its own.
                err_now = (state != IDLE) || (bus.rxdata == SYSEX_END);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cur_status       <= '0;
            run_status       <= '0;
            run_valid        <= 1'b0;
            d1_q             <= '0;
            err_cnt          <= '0;
            bus.msg_valid    <= 1'b0;
            bus.msg_status   <= '0;
            bus.msg_data1    <= '0;
            bus.msg_data2    <= '0;
            bus.msg_len      <= '0;
            bus.rt_valid     <= 1'b0;
            bus.rt_byte      <= '0;
            bus.sysex_active <= 1'b0;
            bus.err_pulse    <= 1'b0;
        end else begin
            bus.msg_valid <= 1'b0;
            bus.rt_valid  <= 1'b0;
            bus.err_pulse <= err_now;
            if (err_now && err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_ONE;
            end

            if (bus.rxdv) begin
                if (is_rt) begin
                    bus.rt_valid <= 1'b1;
                    bus.rt_byte  <= bus.rxdata;
                end else if (is_data) begin
                    unique case (state)
                        IDLE: begin
                            // Running status: this byte is D1 of a new message.
                            if (rs_ok) begin
                                cur_status <= run_status;
                                if (data_count(run_status) == 2'd1) begin
                                    bus.msg_valid  <= 1'b1;
                                    bus.msg_status <= run_status;
                                    bus.msg_data1  <= data7;
                                    bus.msg_data2  <= '0;
                                    bus.msg_len    <= 2'd2;
                                end else begin
                                    d1_q  <= data7;
                                    state <= WAIT_D2;
                                end
                            end
                        end
                        WAIT_D1: begin
                            if (data_count(cur_status) == 2'd1) begin
                                bus.msg_valid  <= 1'b1;
                                bus.msg_status <= cur_status;
                                bus.msg_data1  <= data7;
                                bus.msg_data2  <= '0;
                                bus.msg_len    <= 2'd2;
                                state          <= IDLE;
                            end else begin
                                d1_q  <= data7;
                                state <= WAIT_D2;
                            end
                        end
                        WAIT_D2: begin
                            bus.msg_valid  <= 1'b1;
                            bus.msg_status <= cur_status;
                            bus.msg_data1  <= d1_q;
                            bus.msg_data2  <= data7;
                            bus.msg_len    <= 2'd3;
                            state          <= IDLE;
                        end
                        SYSEX: begin
                        end
                    endcase
                end else if (state == SYSEX && bus.rxdata == SYSEX_END) begin
                    bus.sysex_active <= 1'b0;
                    bus.msg_valid    <= 1'b1;
                    bus.msg_status   <= SYSEX_END;
                    bus.msg_data1    <= '0;
                    bus.msg_data2    <= '0;
                    bus.msg_len      <= 2'd1;
                    state            <= IDLE;
                end else begin
                    // Every state handles a new status identically once the
                    // partial message / SysEx frame has been dropped.
                    bus.sysex_active <= 1'b0;
                    state            <= IDLE;
                    if (bus.rxdata == SYSEX_START) begin
                        run_valid        <= 1'b0;
                        bus.sysex_active <= 1'b1;
                        state            <= SYSEX;
                    end else if (bus.rxdata == TUNE_REQ) begin
                        run_valid      <= 1'b0;
                        bus.msg_valid  <= 1'b1;
                        bus.msg_status <= TUNE_REQ;
                        bus.msg_data1  <= '0;
                        bus.msg_data2  <= '0;
                        bus.msg_len    <= 2'd1;
                    end else if (bus.rxdata == SYSEX_END) begin
                        // Stray F7: flagged by err_now, otherwise ignored.
                    end else if (data_count(bus.rxdata) == 2'd0) begin
                        run_valid <= 1'b0;
                    end else begin
                        cur_status <= bus.rxdata;
                        state      <= WAIT_D1;
                        if (bus.rxdata < SYSEX_START) begin
                            run_status <= bus.rxdata;
                            run_valid  <= 1'b1;
                        end else begin
                            run_valid <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
module tb_midi_msg_parser;

    logic clk;
    logic rst;

    midi_msg_parser_if #(.ERR_CNT_W(8)) bus ();

    midi_msg_parser #(
        .ERR_CNT_W      (8),
        .RUNNING_STATUS (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model: a message is the list of bytes collected so far; it is
    // complete when it holds the status plus that status' data-byte count.
    int         m_run;
    bit         m_sx;
    logic [7:0] m_part[$];
    logic       e_mv;
    logic [7:0] e_ms;
    logic [6:0] e_d1;
    logic [6:0] e_d2;
    logic [1:0] e_len;
    logic       e_rv;
    logic [7:0] e_rb;
    logic       e_ep;
    int         e_cnt;

    function automatic int need(input logic [7:0] s);
        if (s < 8'hF0) return (s[7:4] == 4'hC || s[7:4] == 4'hD) ? 1 : 2;
        if (s == 8'hF1 || s == 8'hF3) return 1;
        if (s == 8'hF2) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_run = -1;
        m_sx  = 1'b0;
        m_part.delete();
        e_mv = 0; e_ms = 0; e_d1 = 0; e_d2 = 0; e_len = 0;
        e_rv = 0; e_rb = 0; e_ep = 0; e_cnt = 0;
    endtask

    task automatic model_emit();
        e_mv  = 1'b1;
        e_ms  = m_part[0];
        e_d1  = (m_part.size() > 1) ? m_part[1][6:0] : 7'd0;
        e_d2  = (m_part.size() > 2) ? m_part[2][6:0] : 7'd0;
        e_len = 2'(m_part.size());
        m_part.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit err;
        err = 1'b0;
        if (b >= 8'hF8) begin
            e_rv = 1'b1;
            e_rb = b;
            return;
        end
        if (b < 8'h80) begin
            if (m_sx) return;
            if (m_part.size() > 0) m_part.push_back(b);
            else if (m_run >= 0) begin
                m_part.push_back(8'(m_run));
                m_part.push_back(b);
            end else err = 1'b1;
            if (m_part.size() > 0 && m_part.size() == 1 + need(m_part[0])) model_emit();
        end else begin
            if (m_sx) begin
                m_sx = 1'b0;
                if (b == 8'hF7) begin
                    m_part.push_back(b);
                    model_emit();
                    return;
                end
                err = 1'b1;
            end
            if (m_part.size() > 0) begin
                err = 1'b1;
                m_part.delete();
            end
            if (b == 8'hF7) err = 1'b1;
            else if (b == 8'hF0) begin m_run = -1; m_sx = 1'b1; end
            else if (b == 8'hF4 || b == 8'hF5) m_run = -1;
            else if (b == 8'hF6) begin m_run = -1; m_part.push_back(b); model_emit(); end
            else if (b > 8'hF0) begin m_run = -1; m_part.push_back(b); end
            else begin m_run = int'(b); m_part.push_back(b); end
        end
        if (err) begin
            e_ep = 1'b1;
            if (e_cnt < 255) e_cnt++;
        end
    endtask

    // Present one byte (or an idle cycle) for one clock; the model advances
    // with it, and on return the DUT outputs for that byte are visible.
    task automatic drive(input logic v, input logic [7:0] b);
        bus.rxdv   = v;
        bus.rxdata = b;
        e_mv = 1'b0; e_rv = 1'b0; e_ep = 1'b0;
        if (v) model_byte(b);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.rxdv = 1'b0;
        bus.rxdata = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [43:0] dut_vec();
        return {bus.msg_valid, bus.msg_status, bus.msg_data1, bus.msg_data2, bus.msg_len,
                bus.rt_valid, bus.rt_byte, bus.sysex_active, bus.err_pulse, bus.err_count};
    endfunction

    function automatic logic [43:0] exp_vec();
        return {e_mv, e_ms, e_d1, e_d2, e_len, e_rv, e_rb, m_sx, e_ep, 8'(e_cnt)};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        bus.rxdv = 1'b1;
        bus.rxdata = 8'h90;
        model_reset();
        @(negedge clk);
        total++;
        if (dut_vec() !== 44'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 44'd0);
        end
        bus.rxdv = 1'b0;
        rst = 1'b1;
        drive(1'b0, 8'h00);
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_running_status();
        logic [7:0] seq[5] = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i]);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL running_status[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i == 2 || i == 4) begin
                total++;
                if ({bus.msg_valid, bus.msg_status, bus.msg_data1, bus.msg_data2, bus.msg_len} !==
                    {1'b1, 8'h90, (i == 2) ? 7'h3C : 7'h3E, (i == 2) ? 7'h64 : 7'h00, 2'd3}) begin
                    bad++;
                    $display("FAIL running_status_msg[%0d]: got %b/%h/%h/%h/%0d", i, bus.msg_valid,
                             bus.msg_status, bus.msg_data1, bus.msg_data2, bus.msg_len);
                end
            end
        end
    endtask

    task automatic test_rt_and_truncation();
        logic [7:0] seq[8] = '{8'hC5, 8'hF8, 8'h07, 8'h90, 8'h3C, 8'hB0, 8'h07, 8'h7F};
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, seq[i]);
            errs += int'(bus.err_pulse);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rt_trunc[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i == 1) begin
                total++;
                if ({bus.rt_valid, bus.rt_byte} !== {1'b1, 8'hF8}) begin
                    bad++;
                    $display("FAIL rt_pulse: got %b/%h want 1/f8", bus.rt_valid, bus.rt_byte);
                end
            end
            if (i == 2) begin
                total++;
                if ({bus.msg_valid, bus.msg_status, bus.msg_data1, bus.msg_len, bus.err_count} !==
                    {1'b1, 8'hC5, 7'h07, 2'd2, 8'd0}) begin
                    bad++;
                    $display("FAIL rt_msg_c5: got %b/%h/%h/%0d cnt=%0d", bus.msg_valid,
                             bus.msg_status, bus.msg_data1, bus.msg_len, bus.err_count);
                end
            end
        end
        total++;
        if (errs !== 1 || bus.err_count !== 8'd1 || bus.msg_status !== 8'hB0) begin
            bad++;
            $display("FAIL truncation: got errs=%0d cnt=%0d status=%h want 1/1/b0",
                     errs, bus.err_count, bus.msg_status);
        end
    endtask

    task automatic test_sysex();
        logic [7:0] seq[5] = '{8'h40, 8'hF0, 8'h01, 8'h02, 8'hF7};
        int hi;
        hi = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i]);
            hi += int'(bus.sysex_active);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL sysex[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i == 0) begin
                total++;
                if ({bus.err_pulse, bus.msg_valid} !== 2'b10) begin
                    bad++;
                    $display("FAIL data_no_status: got err=%b msg=%b want 1/0", bus.err_pulse, bus.msg_valid);
                end
            end
        end
        total++;
        if (hi !== 3 || {bus.msg_valid, bus.msg_status, bus.msg_len} !== {1'b1, 8'hF7, 2'd1}) begin
            bad++;
            $display("FAIL sysex_frame: got hi=%0d msg=%b/%h/%0d want 3/1/f7/1", hi,
                     bus.msg_valid, bus.msg_status, bus.msg_len);
        end
    endtask

    task automatic test_sysex_abort();
        logic [7:0] seq[9] = '{8'hF0, 8'h01, 8'h90, 8'h3C, 8'h64, 8'hF2, 8'h10, 8'h20, 8'h11};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, seq[i]);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL sysex_abort[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i == 7) begin
                total++;
                if ({bus.msg_valid, bus.msg_status, bus.msg_data1, bus.msg_data2, bus.msg_len} !==
                    {1'b1, 8'hF2, 7'h10, 7'h20, 2'd3}) begin
                    bad++;
                    $display("FAIL song_pos: got %b/%h/%h/%h/%0d", bus.msg_valid, bus.msg_status,
                             bus.msg_data1, bus.msg_data2, bus.msg_len);
                end
            end
        end
        total++;
        if (bus.err_pulse !== 1'b1 || bus.err_count !== 8'd2) begin
            bad++;
            $display("FAIL rs_cleared: got err=%b cnt=%0d want 1/2", bus.err_pulse, bus.err_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 8'h90);
        drive(1'b1, 8'h3C);
        rst = 1'b0;
        bus.rxdv = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (dut_vec() !== 44'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h want %h", dut_vec(), 44'd0);
        end
        rst = 1'b1;
        drive(1'b1, 8'h64);
        total++;
        if (dut_vec() !== exp_vec() || bus.err_pulse !== 1'b1 || bus.msg_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_discard: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99);
            if (r < 12) b = 8'hF8 + 8'($urandom_range(7));
            else if (r < 35) b = 8'h80 + 8'($urandom_range(8'h77));
            else b = 8'($urandom_range(127));
            drive($urandom_range(3) != 0, b);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random[%0d] byte=%h: got %h want %h", i, b, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) drive(1'b1, 8'h40);
        drive(1'b0, 8'h00);
        total++;
        if (bus.err_count !== 8'hFF || e_cnt != 255) begin
            bad++;
            $display("FAIL err_saturate: got %h want ff", bus.err_count);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.rxdv = 1'b0;
        bus.rxdata = '0;
        @(negedge clk);
        test_reset();
        test_running_status();
        test_rt_and_truncation();
        test_sysex();
        test_sysex_abort();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Consumes the received byte stream of one midi_port (rxdv/rxdata strobes) and assembles complete MIDI messages: channel voice, system common and real-time.
- Implements running status, tracks SysEx framing and flags protocol errors.
- One instance per port, sitting between midi_port's RX side and the routing logic.
- Routing logic that forwards through midi_port's TX side consumes the message outputs.

Parameters:
- ERR_CNT_W, 8, width of saturating protocol-error counter
- RUNNING_STATUS, 1, 1 = accept data bytes under retained status; 0 = data byte without fresh status is an error

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rxdv  input  1  one-cycle strobe, rxdata valid
- rxdata  input  8  received byte
- msg_valid  output  1  one-cycle pulse, complete message on msg_* outputs
- msg_status  output  8  status byte of message
- msg_data1  output  7  first data byte (0 if unused)
- msg_data2  output  7  second data byte (0 if unused)
- msg_len  output  2  total bytes in message incl. status (1..3)
- rt_valid  output  1  one-cycle pulse, real-time byte on rt_byte
- rt_byte  output  8  real-time status (F8..FF)
- sysex_active  output  1  high between accepted F0 and terminating byte
- err_pulse  output  1  one-cycle pulse on protocol error
- err_count  output  ERR_CNT_W  saturating error count

Behaviour:
- Clock and reset: single clock clk; rst asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, running status cleared, data registers 0. Reset mid-message discards the partial message.
- Timing: one byte accepted per rxdv; no backpressure. All outputs registered; pulses assert the cycle after the rxdv that triggers them.
- Output hold: msg_* data outputs hold their last values between pulses.
- Byte classes:
  - RT: F8..FF
  - STATUS: 80..F7, excluding RT
  - DATA: 00..7F
- RT handling: rt_valid=1 and rt_byte=byte, from any state. No change to state, running status, partial data or sysex_active. An RT byte between data bytes does not break the message.
- Expected data count by status:
  - 8n, 9n, An, Bn, En: 2
  - Cn, Dn: 1
  - F1, F3: 1
  - F2: 2
  - F6: 0; emit immediately with msg_len=1
- States: IDLE, WAIT_D1, WAIT_D2, SYSEX.
- IDLE:
  - DATA byte: if running status is valid and RUNNING_STATUS=1, treat as D1 under the retained status. Otherwise raise error, stay IDLE.
  - STATUS byte: latch it, go to WAIT_D1; F6 emits directly; F0 goes to SYSEX.
- WAIT_D1:
  - DATA byte: latch D1. If count=1, emit msg_len=2; else go to WAIT_D2.
  - STATUS byte: raise error (message truncated), then process the new status as in IDLE.
- WAIT_D2:
  - DATA byte: latch D2, emit msg_len=3.
  - STATUS byte: same as WAIT_D1.
- After emit:
  - Channel status (80..EF): retain as running status, go to IDLE with running status valid. The next DATA byte starts a new message.
  - System common (F1..F6): clears running status, go to IDLE.
- F4, F5 (undefined): clear running status, no emit, no error, go to IDLE.
- F0: clears running status, sysex_active=1, state SYSEX.
- SYSEX:
  - DATA bytes are ignored (not emitted).
  - F7: sysex_active=0, emit F7 with msg_len=1, go to IDLE.
  - Any other STATUS: implicit end. sysex_active=0, raise error, process the byte as in IDLE.
- F7 outside SYSEX: error, ignored.
- Error: err_pulse one cycle; err_count increments, saturating at all-ones.
- Width rules: msg_data1 and msg_data2 take rxdata[6:0]; unused data fields are 0.

Decomposition:
- Shared package midi_pkg: byte-class constants (STATUS_MIN 8'h80, RT_MIN 8'hF8, SYSEX_START 8'hF0, SYSEX_END 8'hF7), the state enum, and a function returning the expected data count for a status byte. The router reuses the function.
- No sub-module; the single FSM plus registers fits within ~200 lines.

Test Plan:
- 90 3C 64 -> one msg_valid, status 90, d1 3C, d2 64, len 3. Then 3E 00 -> second msg_valid, status 90, d1 3E, d2 00, len 3 (running status).
- C5 F8 07 -> rt_valid with rt_byte F8 on the F8 cycle; msg_valid status C5, d1 07, len 2; err_count stays 0.
- 90 3C B0 07 7F -> err_pulse once at B0 (truncated note-on), no msg for 90; msg_valid status B0, d1 07, d2 7F; err_count=1.
- Reset then 40 -> err_pulse, no msg_valid. F0 01 02 F7 -> sysex_active high for 3 cycles, then msg_valid status F7, len 1; the 01/02 bytes are not emitted.
- F0 01 90 3C 64 -> error at 90, sysex_active drops, then msg_valid status 90, d1 3C, d2 64. Follow with F2 10 20 -> msg_valid status F2, d1 10, d2 20, len 3; a subsequent 11 -> error (running status cleared).
- Drive rst low after 90 3C, release, then send 64 -> err_pulse, no msg_valid, all outputs 0 during reset. Force 300 errors with ERR_CNT_W=8 -> err_count saturates at FF.
